// File: rtl/estagio_mem_pkg.sv
// Shared types and constants for the load/store stage and its helpers.
`timescale 1ns/1ps
package estagio_mem_pkg;

  localparam int PROF_MEM = 64;
  localparam int LARG_IDX = 6;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    MEIA    = 2'b01,
    PALAVRA = 2'b10,
    ILEGAL  = 2'b11
  } tamanho_t;

  typedef enum logic [2:0] {
    OCIOSO,
    LEITURA,
    CAPTURA,
    RESPOSTA,
    ESCRITA,
    ERRO
  } estado_t;

  // Alignment rule only; the range check lives in the stage because it depends on depth.
  function automatic logic desalinhado(input tamanho_t tamanho, input logic [1:0] baixo);
    logic r;
    case (tamanho)
      BYTE:    r = 1'b0;
      MEIA:    r = baixo[0];
      PALAVRA: r = (baixo != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/extensor_carga.sv
// Picks the addressed byte/half/word lane out of a memory word and sign- or zero-extends it.
`timescale 1ns/1ps
module extensor_carga
  import estagio_mem_pkg::*;
(
  input  logic [31:0] palavra,
  input  logic [1:0]  endereco_baixo,
  input  tamanho_t    tamanho,
  input  logic        sem_sinal,
  output logic [31:0] resultado
);

  logic [31:0] deslocada;
  logic [7:0]  byte_sel;
  logic [15:0] meia_sel;

  always_comb begin
    deslocada = palavra >> {endereco_baixo, 3'b000};
    byte_sel  = deslocada[7:0];
    meia_sel  = deslocada[15:0];
    resultado = '0;
    case (tamanho)
      BYTE:    resultado = sem_sinal ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEIA:    resultado = sem_sinal ? {16'h0, meia_sel} : {{16{meia_sel[15]}}, meia_sel};
      PALAVRA: resultado = palavra;
      default: resultado = '0;
    endcase
  end

endmodule

// File: rtl/gerador_be.sv
// Maps access size and low address bits to byte enables and lane-replicated store data.
`timescale 1ns/1ps
module gerador_be
  import estagio_mem_pkg::*;
(
  input  logic [1:0]  endereco_baixo,
  input  tamanho_t    tamanho,
  input  logic [31:0] dado,
  output logic [3:0]  be,
  output logic [31:0] dado_replicado
);

  always_comb begin
    be             = 4'b0000;
    dado_replicado = '0;
    case (tamanho)
      BYTE: begin
        be             = 4'b0001 << endereco_baixo;
        dado_replicado = {4{dado[7:0]}};
      end
      MEIA: begin
        be             = 4'b0011 << endereco_baixo;
        dado_replicado = {2{dado[15:0]}};
      end
      PALAVRA: begin
        be             = 4'b1111;
        dado_replicado = dado;
      end
      default: begin
        be             = 4'b0000;
        dado_replicado = '0;
      end
    endcase
  end

endmodule

// File: rtl/estagio_mem.sv
// Load/store stage: one request in flight, fault check at acceptance, memory strobes
// and the write-back register all decoded from the state register.
`timescale 1ns/1ps
module estagio_mem
  import estagio_mem_pkg::*;
#(
  parameter int LARG_DADOS = 32,
  parameter int PROF_MEM   = estagio_mem_pkg::PROF_MEM,
  parameter int LARG_IDX   = estagio_mem_pkg::LARG_IDX
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valido,
  output logic                  req_pronto,
  input  logic                  req_escrita,
  input  logic [1:0]            req_tamanho,
  input  logic                  req_sem_sinal,
  input  logic [31:0]           req_endereco,
  input  logic [LARG_DADOS-1:0] req_dado,
  input  logic [4:0]            req_rd,
  output logic [LARG_IDX-1:0]   mem_endereco,
  output logic                  mem_ler,
  output logic                  mem_escrever,
  output logic [3:0]            mem_be,
  output logic [LARG_DADOS-1:0] mem_dado_escrita,
  input  logic [LARG_DADOS-1:0] mem_dado_leitura,
  output logic                  wb_valido,
  output logic [LARG_DADOS-1:0] wb_dado,
  output logic [4:0]            wb_rd,
  input  logic                  wb_pronto,
  output logic                  excecao,
  output logic [31:0]           excecao_endereco
);

  localparam logic [31:0] LIMITE = 32'(4 * PROF_MEM);

  estado_t               estado, proximo;
  tamanho_t              tamanho_q;
  logic                  sem_sinal_q;
  logic [31:0]           endereco_q;
  logic [LARG_DADOS-1:0] dado_q;
  logic [4:0]            rd_q;
  logic [LARG_DADOS-1:0] wb_dado_q;
  logic [4:0]            wb_rd_q;

  logic                  aceita;
  logic                  falha;
  logic [3:0]            be_calc;
  logic [LARG_DADOS-1:0] dado_rep;
  logic [LARG_DADOS-1:0] extraido;

  assign aceita = (estado == OCIOSO) && req_valido;
  assign falha  = desalinhado(tamanho_t'(req_tamanho), req_endereco[1:0]) ||
                  (req_endereco >= LIMITE);

  gerador_be u_gerador_be (
    .endereco_baixo (endereco_q[1:0]),
    .tamanho        (tamanho_q),
    .dado           (dado_q),
    .be             (be_calc),
    .dado_replicado (dado_rep)
  );

  extensor_carga u_extensor_carga (
    .palavra        (mem_dado_leitura),
    .endereco_baixo (endereco_q[1:0]),
    .tamanho        (tamanho_q),
    .sem_sinal      (sem_sinal_q),
    .resultado      (extraido)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      tamanho_q   <= BYTE;
      sem_sinal_q <= 1'b0;
      endereco_q  <= '0;
      dado_q      <= '0;
      rd_q        <= '0;
      wb_dado_q   <= '0;
      wb_rd_q     <= '0;
    end else begin
      estado <= proximo;
      if (aceita) begin
        tamanho_q   <= tamanho_t'(req_tamanho);
        sem_sinal_q <= req_sem_sinal;
        endereco_q  <= req_endereco;
        dado_q      <= req_dado;
        rd_q        <= req_rd;
      end
      // Read data is valid only during CAPTURA, so the extended result is latched there.
      if (estado == CAPTURA) begin
        wb_dado_q <= extraido;
        wb_rd_q   <= rd_q;
      end
    end
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO: begin
        if (req_valido) begin
          if (falha)            proximo = ERRO;
          else if (req_escrita) proximo = ESCRITA;
          else                  proximo = LEITURA;
        end
      end
      LEITURA:  proximo = CAPTURA;
      CAPTURA:  proximo = RESPOSTA;
      RESPOSTA: if (wb_pronto) proximo = OCIOSO;
      ESCRITA:  proximo = OCIOSO;
      ERRO:     proximo = OCIOSO;
      default:  proximo = OCIOSO;
    endcase
  end

  // Memory-side signals are forced to zero outside their strobe cycle.
  always_comb begin
    req_pronto       = 1'b0;
    mem_ler          = 1'b0;
    mem_escrever     = 1'b0;
    mem_endereco     = '0;
    mem_be           = 4'b0000;
    mem_dado_escrita = '0;
    wb_valido        = 1'b0;
    excecao          = 1'b0;
    excecao_endereco = '0;
    case (estado)
      OCIOSO: req_pronto = 1'b1;
      LEITURA: begin
        mem_ler      = 1'b1;
        mem_endereco = endereco_q[LARG_IDX+1:2];
      end
      ESCRITA: begin
        mem_escrever     = 1'b1;
        mem_endereco     = endereco_q[LARG_IDX+1:2];
        mem_be           = be_calc;
        mem_dado_escrita = dado_rep;
      end
      RESPOSTA: wb_valido = 1'b1;
      ERRO: begin
        excecao          = 1'b1;
        excecao_endereco = endereco_q;
      end
      default: ;
    endcase
  end

  assign wb_dado = wb_dado_q;
  assign wb_rd   = wb_rd_q;

endmodule
